// File: rtl/hpel_sad_select.sv
// hpel_sad_select: per-candidate 16x16 SAD accumulation over the half-pel
// stream, followed by a minimum-SAD search. Ties keep the lower candidate index.
//
// Optional build macro HPEL_SAD_EARLY_TERM_EN: abandons a candidate once its
// running SAD exceeds the current best. When the macro is undefined, skip_cnt
// is held at 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start, in_ready low
// S_ACCUM | accepting pixels of the current candidate
// S_DRAIN | adding the last registered |diff| into acc
// S_CMP   | compare acc against the best so far, advance candidate
// S_DONE  | result presented, done pulse
module hpel_sad_select #(
    parameter int NUM_CAND     = 8,
    parameter int PIX_PER_CAND = 256,
    parameter int SAD_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       half_pix,
    input  logic [7:0]       cur_pix,
    output logic             busy,
    output logic             done,
    output logic [3:0]       best_cand,
    output logic [SAD_W-1:0] best_sad,
    output logic [3:0]       skip_cnt
);

    localparam int PW = (PIX_PER_CAND > 1) ? $clog2(PIX_PER_CAND) : 1;
    localparam logic [PW-1:0] LAST_PIX  = PW'(PIX_PER_CAND - 1);
    localparam logic [3:0]    LAST_CAND = 4'(NUM_CAND - 1);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_CMP, S_DONE} state_t;

    state_t           state;
    logic [3:0]       cand_cnt;
    logic [PW-1:0]    pix_cnt;
    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] best_sad_int;
    logic [3:0]       best_cand_int;
    logic [7:0]       d;
    logic             d_vld;
    logic             abandon;

    logic             xfer;
    logic [7:0]       mag;
    logic [SAD_W-1:0] acc_next;
    logic             cmp_win;

    assign xfer     = in_valid && in_ready;
    assign mag      = (half_pix >= cur_pix) ? (half_pix - cur_pix) : (cur_pix - half_pix);
    assign acc_next = d_vld ? (acc + {{(SAD_W-8){1'b0}}, d}) : acc;
    assign cmp_win  = !abandon && (acc < best_sad_int);

    // Pipeline stage: register the absolute difference of each accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d     <= '0;
            d_vld <= 1'b0;
        end else begin
            d_vld <= xfer;
            if (xfer) d <= mag;
        end
    end

    // Main controller: sequencing, accumulation, compare and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            best_cand     <= '0;
            best_sad      <= '0;
            cand_cnt      <= '0;
            pix_cnt       <= '0;
            acc           <= '0;
            best_sad_int  <= '0;
            best_cand_int <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cand_cnt      <= '0;
                        pix_cnt       <= '0;
                        acc           <= '0;
                        best_sad_int  <= '1;
                        best_cand_int <= '0;
                        busy          <= 1'b1;
                        in_ready      <= 1'b1;
                        state         <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (!abandon) acc <= acc_next;
                    if (xfer) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == LAST_PIX) begin
                            in_ready <= 1'b0;
                            state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!abandon) acc <= acc_next;
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (cmp_win) begin
                        best_sad_int  <= acc;
                        best_cand_int <= cand_cnt;
                    end
                    acc     <= '0;
                    pix_cnt <= '0;
                    if (cand_cnt == LAST_CAND) begin
                        // Result registers load here so they are valid alongside done.
                        best_cand <= cmp_win ? cand_cnt : best_cand_int;
                        best_sad  <= cmp_win ? acc : best_sad_int;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        cand_cnt <= cand_cnt + 1'b1;
                        in_ready <= 1'b1;
                        state    <= S_ACCUM;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HPEL_SAD_EARLY_TERM_EN
    // Early termination: abandon a candidate once its running SAD passes the best.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abandon  <= 1'b0;
            skip_cnt <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                abandon  <= 1'b0;
                skip_cnt <= '0;
            end else if (state == S_ACCUM) begin
                if (acc_next > best_sad_int) abandon <= 1'b1;
            end else if (state == S_CMP) begin
                abandon <= 1'b0;
                if (abandon && skip_cnt != 4'd15) skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end
`else
    assign abandon  = 1'b0;
    assign skip_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_hpel_sad_select.sv
// Self-checking bench for hpel_sad_select: directed macroblock patterns,
// gapped streams, start-while-busy, and reset abort.
module tb_hpel_sad_select;

    localparam int NC = 8;
    localparam int PP = 256;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    half_pix;
    logic [7:0]    cur_pix;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [3:0]    best_cand;
    logic [SW-1:0] best_sad;
    logic [3:0]    skip_cnt;

    hpel_sad_select #(.NUM_CAND(NC), .PIX_PER_CAND(PP), .SAD_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .half_pix(half_pix), .cur_pix(cur_pix), .busy(busy), .done(done),
        .best_cand(best_cand), .best_sad(best_sad), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_cand, exp_sad, exp_skip;
    int done_cnt = 0, done_cyc = 0, xfer_cnt = 0, last_xfer = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Stimulus pixel for (pattern, candidate, pixel): {half_pix, cur_pix}.
    function automatic logic [15:0] gen(input int pat, input int c, input int p);
        int h, cu;
        case (pat)
            1: begin cu = (p * 7 + c * 13) & 255; h = (c == 5) ? 0 : cu; end
            2: begin cu = 100; h = 108 - c; end
            3: begin
                if (c == 0) begin h = 255; cu = 0; end
                else begin h = 0; cu = 255; end
            end
            4: begin cu = 100; h = (c == 0) ? 101 : 102; end
            default: begin
                h  = (p * 29 + c * 53 + (p >> 3) * 17) & 255;
                cu = (p * 13 + 77) & 255;
            end
        endcase
        return {8'(h), 8'(cu)};
    endfunction

    // Reference: SAD per candidate, strict-less minimum search (ties keep the
    // lower index). With early termination, a candidate whose running sum
    // exceeds the best before its final pixel lands is counted as skipped.
    task automatic model_mb(input int pat);
        int best, bc, sk, sad, part, dif;
        logic [15:0] v;
        best = (1 << SW) - 1; bc = 0; sk = 0;
        for (int c = 0; c < NC; c++) begin
            sad = 0; part = 0;
            for (int p = 0; p < PP; p++) begin
                v = gen(pat, c, p);
                dif = int'(v[15:8]) - int'(v[7:0]);
                if (dif < 0) dif = -dif;
                sad += dif;
                if (p < PP - 1) part += dif;
            end
`ifdef HPEL_SAD_EARLY_TERM_EN
            if (part > best) begin
                if (sk < 15) sk++;
            end else if (sad < best) begin
                best = sad; bc = c;
            end
`else
            if (sad < best) begin best = sad; bc = c; end
`endif
        end
        exp_cand = bc; exp_sad = best; exp_skip = sk;
    endtask

    // Compare process: transfer accounting every cycle, result check on done.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            xfer_cnt++;
            last_xfer = cyc;
        end
        if (!rst && done) begin
            done_cnt++;
            done_cyc = cyc;
            check("best_cand", 32'(best_cand), 32'(exp_cand));
            check("best_sad", 32'(best_sad), 32'(exp_sad));
            check("skip_cnt", 32'(skip_cnt), 32'(exp_skip));
            check("busy_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_mb(input string tag, input int pat, input bit gaps, input bit restart);
        int tmo;
        bit accepted, stalled;
        logic [15:0] v;
        logic [3:0] prev_cand;
        logic [SW-1:0] prev_sad;
        xfer_cnt = 0; done_cnt = 0; stalled = 0;
        prev_cand = best_cand; prev_sad = best_sad;
        pulse_start();
        for (int c = 0; c < NC && !stalled; c++) begin
            for (int p = 0; p < PP && !stalled; p++) begin
                v = gen(pat, c, p);
                half_pix = v[15:8];
                cur_pix  = v[7:0];
                if (restart && c == 3 && p == 10) start = 1'b1;
                tmo = 0;
                do begin
                    in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(negedge clk);
                    accepted = in_valid && in_ready;
                    if (c == 0 && p == 0 && tmo == 0) begin
                        check({tag, "_busy"}, 32'(busy), 32'd1);
                        check({tag, "_ready"}, 32'(in_ready), 32'd1);
                    end
                    if (c == 4 && p == 0 && tmo == 0) begin
                        check({tag, "_hold_cand"}, 32'(best_cand), 32'(prev_cand));
                        check({tag, "_hold_sad"}, 32'(best_sad), 32'(prev_sad));
                    end
                    @(posedge clk); #1;
                    start = 1'b0;
                    tmo++;
                end while (!accepted && tmo < 50);
                if (!accepted) begin
                    tests++; fails++;
                    $display("FAIL %s_stall: pixel %0d of cand %0d not accepted within 50 cycles", tag, p, c);
                    stalled = 1;
                end
            end
        end
        in_valid = 1'b0;
        tmo = 0;
        while (done_cnt == 0 && tmo < 20) begin
            @(negedge clk); #1;
            tmo++;
        end
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_xfers"}, 32'(xfer_cnt), 32'(NC * PP));
        // Transfer completes on the edge after last_xfer was sampled.
        check({tag, "_done_latency"}, 32'(done_cyc - (last_xfer + 1)), 32'd2);
    endtask

    task automatic abort_test();
        logic [15:0] v;
        xfer_cnt = 0; done_cnt = 0;
        pulse_start();
        for (int p = 0; p < 100; p++) begin
            v = gen(2, 0, p);
            half_pix = v[15:8]; cur_pix = v[7:0]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_xfers", 32'(xfer_cnt), 32'd100);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (600) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; half_pix = '0; cur_pix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cand", 32'(best_cand), 32'd0);
        check("rst_sad", 32'(best_sad), 32'd0);
        check("rst_skip", 32'(skip_cnt), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        abort_test();

        model_mb(2);
        check("model_ramp_cand", 32'(exp_cand), 32'd7);
        check("model_ramp_sad", 32'(exp_sad), 32'd256);
        run_mb("ramp", 2, 1'b0, 1'b0);

        model_mb(1);
        check("model_tie_cand", 32'(exp_cand), 32'd0);
        check("model_tie_sad", 32'(exp_sad), 32'd0);
        run_mb("tie", 1, 1'b0, 1'b0);

        model_mb(3);
        check("model_max_cand", 32'(exp_cand), 32'd0);
        check("model_max_sad", 32'(exp_sad), 32'd65280);
        run_mb("max", 3, 1'b0, 1'b0);

        model_mb(2);
        run_mb("gap_restart", 2, 1'b1, 1'b1);

        model_mb(5);
        run_mb("gap_rand", 5, 1'b1, 1'b0);

        model_mb(4);
        check("model_et_cand", 32'(exp_cand), 32'd0);
        check("model_et_sad", 32'(exp_sad), 32'd256);
`ifdef HPEL_SAD_EARLY_TERM_EN
        check("model_et_skip", 32'(exp_skip), 32'd7);
`else
        check("model_et_skip", 32'(exp_skip), 32'd0);
`endif
        run_mb("early_term", 4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
